// File: rtl/video_sig_gen.sv
// video_sig_gen: raster timing generator for the render stage.
// Produces pixel coordinates, active-draw flag, h/v sync and a one-cycle
// new-frame strobe, all registered and aligned to the same position.
// Optional feature: define FRAME_COUNT_EN to build the fc_out frame counter
// (modulo FRAME_WRAP). Without it fc_out is tied to zero and no counter exists.
module video_sig_gen #(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int H_FRONT_PORCH   = 110,
  parameter int H_SYNC_WIDTH    = 40,
  parameter int H_BACK_PORCH    = 220,
  parameter int ACTIVE_LINES    = 720,
  parameter int V_FRONT_PORCH   = 5,
  parameter int V_SYNC_WIDTH    = 5,
  parameter int V_BACK_PORCH    = 20,
  parameter int FRAME_WRAP      = 60
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        ad_out,
  output logic        nf_out,
  output logic [5:0]  fc_out
);

  localparam int TOTAL_PIXELS = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int TOTAL_LINES  = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

  // Region boundaries are one bit wider than the counters so an edge that
  // lands exactly on the counter range limit does not alias to zero.
  localparam logic [10:0] H_LAST     = 11'(TOTAL_PIXELS - 1);
  localparam logic [9:0]  V_LAST     = 10'(TOTAL_LINES - 1);
  localparam logic [11:0] H_ACT_END  = 12'(ACTIVE_H_PIXELS);
  localparam logic [11:0] HS_START   = 12'(ACTIVE_H_PIXELS + H_FRONT_PORCH);
  localparam logic [11:0] HS_END     = 12'(ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH);
  localparam logic [10:0] V_ACT_END  = 11'(ACTIVE_LINES);
  localparam logic [10:0] VS_START   = 11'(ACTIVE_LINES + V_FRONT_PORCH);
  localparam logic [10:0] VS_END     = 11'(ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH);

  // Reject geometries that cannot be represented on the fixed-width ports.
  if (TOTAL_PIXELS > 2048 || TOTAL_LINES > 1024 || FRAME_WRAP < 1 || FRAME_WRAP > 64) begin : g_bad_params
    $error("video_sig_gen: timing parameters exceed output port widths");
  end

  logic        running_reg;
  logic [10:0] h_next;
  logic [9:0]  v_next;
  logic        hs_next;
  logic        vs_next;
  logic        ad_next;
  logic        nf_next;

  // Next raster position: (0,0) on the first edge after reset, otherwise one
  // pixel further with line and frame wrap.
  always_comb begin
    h_next = '0;
    v_next = '0;
    if (running_reg) begin
      if (hcount_out == H_LAST) begin
        h_next = '0;
        if (vcount_out == V_LAST) begin
          v_next = '0;
        end else begin
          v_next = vcount_out + 10'd1;
        end
      end else begin
        h_next = hcount_out + 11'd1;
        v_next = vcount_out;
      end
    end
  end

  // Decode the flags from the next position so they register alongside it.
  always_comb begin
    hs_next = ({1'b0, h_next} >= HS_START) && ({1'b0, h_next} < HS_END);
    vs_next = ({1'b0, v_next} >= VS_START) && ({1'b0, v_next} < VS_END);
    ad_next = ({1'b0, h_next} < H_ACT_END) && ({1'b0, v_next} < V_ACT_END);
    nf_next = ({1'b0, h_next} == H_ACT_END) && ({1'b0, v_next} == V_ACT_END);
  end

  // Output registers; reset clears everything immediately, truncating any sync pulse.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      running_reg <= 1'b0;
      hcount_out  <= '0;
      vcount_out  <= '0;
      hs_out      <= 1'b0;
      vs_out      <= 1'b0;
      ad_out      <= 1'b0;
      nf_out      <= 1'b0;
    end else begin
      running_reg <= 1'b1;
      hcount_out  <= h_next;
      vcount_out  <= v_next;
      hs_out      <= hs_next;
      vs_out      <= vs_next;
      ad_out      <= ad_next;
      nf_out      <= nf_next;
    end
  end

`ifdef FRAME_COUNT_EN
  localparam logic [5:0] FC_LAST = 6'(FRAME_WRAP - 1);

  logic [5:0] fc_reg;

  // Frame counter steps on the same edge that raises nf_out.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      fc_reg <= '0;
    end else if (nf_next) begin
      fc_reg <= (fc_reg == FC_LAST) ? 6'd0 : fc_reg + 6'd1;
    end
  end

  assign fc_out = fc_reg;
`else
  assign fc_out = 6'd0;
`endif

endmodule

// File: tb/tb_video_sig_gen.sv
// tb_video_sig_gen: checks video_sig_gen against a position-from-cycle-index model.
// A reduced-geometry instance covers whole frames; a default-geometry instance
// covers the first line of 1280x720 timing.
module tb_video_sig_gen;

  localparam int S_AH = 16, S_HFP = 3, S_HSW = 4, S_HBP = 5;
  localparam int S_AL = 10, S_VFP = 2, S_VSW = 3, S_VBP = 4;
  localparam int S_WRAP = 5;
  localparam int S_TH = S_AH + S_HFP + S_HSW + S_HBP;
  localparam int S_FRAME = S_TH * (S_AL + S_VFP + S_VSW + S_VBP);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [10:0] hcount_s, hcount_d;
  logic [9:0]  vcount_s, vcount_d;
  logic        hs_s, vs_s, ad_s, nf_s, hs_d, vs_d, ad_d, nf_d;
  logic [5:0]  fc_s, fc_d;
  logic [30:0] act_s, act_d;

  assign act_s = {hcount_s, vcount_s, hs_s, vs_s, ad_s, nf_s, fc_s};
  assign act_d = {hcount_d, vcount_d, hs_d, vs_d, ad_d, nf_d, fc_d};

  video_sig_gen #(
    .ACTIVE_H_PIXELS(S_AH), .H_FRONT_PORCH(S_HFP), .H_SYNC_WIDTH(S_HSW), .H_BACK_PORCH(S_HBP),
    .ACTIVE_LINES(S_AL), .V_FRONT_PORCH(S_VFP), .V_SYNC_WIDTH(S_VSW), .V_BACK_PORCH(S_VBP),
    .FRAME_WRAP(S_WRAP)
  ) dut_s (
    .pixel_clk_in(clk), .rst_in(rst), .hcount_out(hcount_s), .vcount_out(vcount_s),
    .hs_out(hs_s), .vs_out(vs_s), .ad_out(ad_s), .nf_out(nf_s), .fc_out(fc_s)
  );

  video_sig_gen dut_d (
    .pixel_clk_in(clk), .rst_in(rst), .hcount_out(hcount_d), .vcount_out(vcount_d),
    .hs_out(hs_d), .vs_out(vs_d), .ad_out(ad_d), .nf_out(nf_d), .fc_out(fc_d)
  );

  // Edges seen since reset released; 0 means nothing has been presented yet.
  longint edges;
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  int checks = 0;
  int passes = 0;

  // Position k (0-based cycle since start) -> expected outputs, from the raster rules.
  function automatic logic [30:0] model(input int ah, hfp, hsw, hbp, al, vfp, vsw, vbp, wrap,
                                        input longint k);
    longint th, tv, f, pos, h, v, off, nfc;
    logic hs, vs, ad, nf;
    logic [5:0] fc;
    th  = ah + hfp + hsw + hbp;
    tv  = al + vfp + vsw + vbp;
    f   = th * tv;
    pos = k % f;
    h   = pos % th;
    v   = pos / th;
    hs  = (h >= ah + hfp) && (h < ah + hfp + hsw);
    vs  = (v >= al + vfp) && (v < al + vfp + vsw);
    ad  = (h < ah) && (v < al);
    off = al * th + ah;
    nf  = (pos == off);
    nfc = (k >= off) ? ((k - off) / f + 1) : 0;
`ifdef FRAME_COUNT_EN
    fc = 6'(nfc % wrap);
`else
    fc = 6'd0;
`endif
    return {11'(h), 10'(v), hs, vs, ad, nf, fc};
  endfunction

  function automatic logic [30:0] exp_s(input longint e);
    if (e == 0) return '0;
    return model(S_AH, S_HFP, S_HSW, S_HBP, S_AL, S_VFP, S_VSW, S_VBP, S_WRAP, e - 1);
  endfunction

  function automatic logic [30:0] exp_d(input longint e);
    if (e == 0) return '0;
    return model(1280, 110, 40, 220, 720, 5, 5, 20, 60, e - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (act_s !== 31'd0) $display("FAIL reset_hold_s: got %h expected 0", act_s); else passes++;
    checks++; if (act_d !== 31'd0) $display("FAIL reset_hold_d: got %h expected 0", act_d); else passes++;
    #3 rst = 1'b0;
    tick();
    checks++; if (act_s !== 31'h80) $display("FAIL first_edge_s: got %h expected 80", act_s); else passes++;
    checks++; if (act_d !== 31'h80) $display("FAIL first_edge_d: got %h expected 80", act_d); else passes++;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (act_s !== 31'd0) $display("FAIL async_reset_s: got %h expected 0", act_s); else passes++;
    checks++; if (act_d !== 31'd0) $display("FAIL async_reset_d: got %h expected 0", act_d); else passes++;
    tick();
    #3 rst = 1'b0;
    tick();
    checks++; if (act_s !== 31'h80) $display("FAIL restart_s: got %h expected 80", act_s); else passes++;
  endtask

  task automatic test_default_line();
    int hs_cnt = 0;
    int hs_first = -1;
    int ad_fall = -1;
    logic [20:0] wrap_pos = '1;
    while (edges < 1652) begin
      tick();
      checks++;
      if (act_d !== exp_d(edges))
        $display("FAIL line_d k=%0d: got %h expected %h", edges - 1, act_d, exp_d(edges));
      else passes++;
      if (vcount_d == 0 && hs_d) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(hcount_d);
      end
      if (vcount_d == 0 && !ad_d && ad_fall < 0) ad_fall = int'(hcount_d);
      if (edges - 1 == 1650) wrap_pos = {hcount_d, vcount_d};
    end
    checks++; if (hs_cnt != 40) $display("FAIL hs_width: got %0d expected 40", hs_cnt); else passes++;
    checks++; if (hs_first != 1390) $display("FAIL hs_start: got %0d expected 1390", hs_first); else passes++;
    checks++; if (ad_fall != 1280) $display("FAIL ad_fall: got %0d expected 1280", ad_fall); else passes++;
    checks++; if (wrap_pos !== {11'd0, 10'd1}) $display("FAIL line_wrap: got %h expected %h", wrap_pos, {11'd0, 10'd1}); else passes++;
  endtask

  task automatic test_frames();
    longint nf_at[$];
    int vs_cnt = 0;
    int guard = 0;
    while (nf_at.size() < 3 && guard < 4 * S_FRAME) begin
      tick();
      guard++;
      checks++;
      if (act_s !== exp_s(edges))
        $display("FAIL frame_s k=%0d: got %h expected %h", edges - 1, act_s, exp_s(edges));
      else passes++;
      if (nf_at.size() >= 1 && vs_s) vs_cnt++;
      if (nf_s) begin
        nf_at.push_back(edges);
        checks++;
        if (hcount_s != 11'(S_AH) || vcount_s != 10'(S_AL))
          $display("FAIL nf_pos: got (%0d,%0d) expected (%0d,%0d)", hcount_s, vcount_s, S_AH, S_AL);
        else passes++;
      end
    end
    checks++;
    if (nf_at.size() != 3) $display("FAIL nf_count: got %0d expected 3", nf_at.size());
    else begin
      passes++;
      checks++;
      if (nf_at[1] - nf_at[0] != S_FRAME || nf_at[2] - nf_at[1] != S_FRAME)
        $display("FAIL nf_spacing: got %0d,%0d expected %0d", nf_at[1] - nf_at[0], nf_at[2] - nf_at[1], S_FRAME);
      else passes++;
      checks++;
      if (vs_cnt != 2 * S_VSW * S_TH) $display("FAIL vs_cycles: got %0d expected %0d", vs_cnt, 2 * S_VSW * S_TH);
      else passes++;
    end
  endtask

  task automatic test_frame_counter();
    int n = 0;
    int guard = 0;
    logic [5:0] want;
    #2 rst = 1'b1;
    tick();
    #3 rst = 1'b0;
    while (n < 2 * S_WRAP + 1 && guard < (2 * S_WRAP + 2) * S_FRAME) begin
      tick();
      guard++;
      if (nf_s) begin
        n++;
`ifdef FRAME_COUNT_EN
        want = 6'(n % S_WRAP);
`else
        want = 6'd0;
`endif
        checks++;
        if (fc_s !== want) $display("FAIL fc_step n=%0d: got %0d expected %0d", n, fc_s, want);
        else passes++;
      end
    end
    checks++;
    if (n != 2 * S_WRAP + 1) $display("FAIL fc_frames: got %0d expected %0d", n, 2 * S_WRAP + 1);
    else passes++;
    checks++;
    if (fc_d !== 6'd0) $display("FAIL fc_default: got %0d expected 0", fc_d); else passes++;
  endtask

  task automatic test_reset_mid_sync();
    int guard = 0;
    while (!(hs_s && hcount_s == 11'(S_AH + S_HFP + 1)) && guard < 2 * S_FRAME) begin
      tick();
      guard++;
    end
    checks++;
    if (guard >= 2 * S_FRAME) $display("FAIL sync_reach: got timeout expected hsync"); else passes++;
    #2 rst = 1'b1;
    #1;
    checks++; if (hs_s !== 1'b0) $display("FAIL sync_trunc: got hs=%b expected 0", hs_s); else passes++;
    checks++; if (act_s !== 31'd0) $display("FAIL sync_reset: got %h expected 0", act_s); else passes++;
    tick();
    #3 rst = 1'b0;
    tick();
    checks++; if (act_s !== 31'h80) $display("FAIL sync_restart: got %h expected 80", act_s); else passes++;
    repeat (S_FRAME) begin
      tick();
      checks++;
      if (act_s !== exp_s(edges))
        $display("FAIL after_sync_s k=%0d: got %h expected %h", edges - 1, act_s, exp_s(edges));
      else passes++;
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int len = int'($urandom_range(1200, 20));
      int hold = int'($urandom_range(3, 1));
      repeat (len) begin
        tick();
        checks++;
        if (act_s !== exp_s(edges))
          $display("FAIL rand_s k=%0d: got %h expected %h", edges - 1, act_s, exp_s(edges));
        else passes++;
        checks++;
        if (act_d !== exp_d(edges))
          $display("FAIL rand_d k=%0d: got %h expected %h", edges - 1, act_d, exp_d(edges));
        else passes++;
      end
      #($urandom_range(3, 1)) rst = 1'b1;
      #1;
      checks++; if (act_s !== 31'd0) $display("FAIL rand_rst_s: got %h expected 0", act_s); else passes++;
      checks++; if (act_d !== 31'd0) $display("FAIL rand_rst_d: got %h expected 0", act_d); else passes++;
      repeat (hold) tick();
      checks++; if (act_s !== 31'd0) $display("FAIL rand_hold_s: got %h expected 0", act_s); else passes++;
      #($urandom_range(4, 1)) rst = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_default_line();
    test_frames();
    test_frame_counter();
    test_reset_mid_sync();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
